// File: rtl/ls193_pulse_sequencer.sv
// ----------------------------------------------------------------------------
// ls193_pulse_sequencer
//
// Command-driven controller for a single 74LS193-style 4-bit up/down counter.
// Each accepted command (clear, load, count up N, count down N) is turned into
// correctly timed pulses on the counter's MR, /PL, CPu and CPd pins. A shadow
// count runs in parallel and is compared against the counter's Q outputs once
// every command, and carry/borrow terminal counts are folded into a wrap flag.
//
// Parameters
//   PULSE_W    clocks per pulse phase (low/high of CPu/CPd, length of MR and
//              /PL assertion), 1..15
//
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset; also clears the counter
//   cmd_valid  command request
//   cmd_ready  high only while idle; accept = cmd_valid && cmd_ready
//   cmd_op     00 clear, 01 load, 10 count up, 11 count down
//   cmd_data   load value, or pulse count N (0 means 16)
//   ctr_data   counter parallel data (P inputs)
//   ctr_clr    counter master reset (MR)
//   ctr_load_n counter parallel load, active low (/PL)
//   ctr_up     counter CPu
//   ctr_down   counter CPd
//   ctr_q      counter Q outputs
//   ctr_co     counter /TCu
//   ctr_bo     counter /TCd
//   busy       high in every state except idle
//   done       one-cycle pulse when a command completes
//   wrap       the last count command passed 15 (up) or 0 (down)
//   q_err      ctr_q differed from the shadow count at the last check
// ----------------------------------------------------------------------------
module ls193_pulse_sequencer #(
    parameter int PULSE_W = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] ctr_data,
    output logic       ctr_clr,
    output logic       ctr_load_n,
    output logic       ctr_up,
    output logic       ctr_down,
    input  logic [3:0] ctr_q,
    input  logic       ctr_co,
    input  logic       ctr_bo,
    output logic       busy,
    output logic       done,
    output logic       wrap,
    output logic       q_err
);

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [3:0] TMR_INIT = 4'(PULSE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_ASSERT,
        S_LOAD_ASSERT,
        S_PULSE_LO,
        S_PULSE_HI,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [3:0] r_tmr;
    logic [4:0] r_rem;
    logic [1:0] r_op;
    logic [3:0] r_shadow;
    logic [3:0] r_ctr_data;
    logic       r_wrap;
    logic       r_q_err;

    logic       w_tmr_last;
    logic       w_accept;
    logic       w_up_op;
    logic       w_fsm_clear;
    logic       w_load_n;
    logic       w_up;
    logic       w_down;
    logic       w_done;

    assign w_tmr_last = (r_tmr == 4'd0);
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    assign w_up_op    = (r_op == OP_UP);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and counter-pin decode
    always_comb begin
        w_state_nx  = r_state;
        w_fsm_clear = 1'b0;
        w_load_n    = 1'b1;
        w_up        = 1'b1;
        w_down      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLR:  w_state_nx = S_CLR_ASSERT;
                        OP_LOAD: w_state_nx = S_LOAD_ASSERT;
                        default: w_state_nx = S_PULSE_LO;
                    endcase
                end
            end
            S_CLR_ASSERT: begin
                w_fsm_clear = 1'b1;
                if (w_tmr_last) w_state_nx = S_SETTLE;
            end
            S_LOAD_ASSERT: begin
                w_load_n = 1'b0;
                if (w_tmr_last) w_state_nx = S_SETTLE;
            end
            S_PULSE_LO: begin
                // Only the selected clock drops; the other stays high so the
                // counter sees exactly one rising edge per pulse.
                if (w_up_op) w_up   = 1'b0;
                else         w_down = 1'b0;
                if (w_tmr_last) w_state_nx = S_PULSE_HI;
            end
            S_PULSE_HI: begin
                // r_rem was already decremented on entry to this phase.
                if (w_tmr_last) w_state_nx = (r_rem == 5'd0) ? S_SETTLE : S_PULSE_LO;
            end
            S_SETTLE: begin
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Phase timer: reloaded on every state change, counts down to zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_tmr <= 4'd0;
        end else if (w_state_nx != r_state) begin
            r_tmr <= TMR_INIT;
        end else if (!w_tmr_last) begin
            r_tmr <= r_tmr - 4'd1;
        end
    end

    // Command latch, shadow count and status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op       <= OP_CLR;
            r_rem      <= 5'd0;
            r_shadow   <= 4'd0;
            r_ctr_data <= 4'd0;
            r_wrap     <= 1'b0;
            r_q_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op;
                r_wrap <= 1'b0;
                r_rem  <= {(cmd_data == 4'd0), cmd_data};
                if (cmd_op == OP_LOAD) r_ctr_data <= cmd_data;
            end
            if (r_state == S_CLR_ASSERT && w_tmr_last) begin
                r_shadow <= 4'd0;
            end
            if (r_state == S_LOAD_ASSERT && w_tmr_last) begin
                r_shadow <= r_ctr_data;
            end
            // The edge leaving PULSE_LO is the counter's count edge, so the
            // shadow steps together with the real counter. The terminal-count
            // pins are only meaningful while the clock is low, hence sampling
            // on the last low cycle.
            if (r_state == S_PULSE_LO && w_tmr_last) begin
                if (w_up_op ? !ctr_co : !ctr_bo) r_wrap <= 1'b1;
                r_shadow <= w_up_op ? (r_shadow + 4'd1) : (r_shadow - 4'd1);
                r_rem    <= r_rem - 5'd1;
            end
            if (r_state == S_SETTLE) begin
                r_q_err <= (ctr_q != r_shadow);
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign wrap       = r_wrap;
    assign q_err      = r_q_err;
    assign ctr_data   = r_ctr_data;
    assign ctr_clr    = clr | w_fsm_clear;
    assign ctr_load_n = w_load_n;
    assign ctr_up     = w_up;
    assign ctr_down   = w_down;

endmodule

// File: tb/tb_ls193_pulse_sequencer.sv
// ----------------------------------------------------------------------------
// Bench for ls193_pulse_sequencer with a behavioural 74LS193 counter model.
// ----------------------------------------------------------------------------
module tb_ls193_pulse_sequencer;

    localparam int PW = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] ctr_data;
    logic       ctr_clr;
    logic       ctr_load_n;
    logic       ctr_up;
    logic       ctr_down;
    logic [3:0] ctr_q;
    logic       ctr_co;
    logic       ctr_bo;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       q_err;

    always #5 clk = ~clk;

    ls193_pulse_sequencer #(.PULSE_W(PW)) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .ctr_data   (ctr_data),
        .ctr_clr    (ctr_clr),
        .ctr_load_n (ctr_load_n),
        .ctr_up     (ctr_up),
        .ctr_down   (ctr_down),
        .ctr_q      (ctr_q),
        .ctr_co     (ctr_co),
        .ctr_bo     (ctr_bo),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .q_err      (q_err)
    );

    // Counter model: MR, then /PL, then one count per rising CPu/CPd while
    // the other clock is high. drop_arm swallows a single up pulse.
    logic [3:0] q_m;
    logic       prev_up = 1'b1;
    logic       prev_dn = 1'b1;
    logic       drop_arm = 1'b0;
    logic       dropped = 1'b0;

    always @(negedge clk) begin
        if (ctr_clr) q_m <= 4'd0;
        else if (!ctr_load_n) q_m <= ctr_data;
        else if (!prev_up && ctr_up && ctr_down) begin
            if (drop_arm && !dropped) dropped <= 1'b1;
            else q_m <= q_m + 4'd1;
        end else if (!prev_dn && ctr_down && ctr_up) q_m <= q_m - 4'd1;
        if (!drop_arm) dropped <= 1'b0;
        prev_up <= ctr_up;
        prev_dn <= ctr_down;
    end

    assign ctr_q  = q_m;
    assign ctr_co = !((q_m == 4'd15) && !ctr_up);
    assign ctr_bo = !((q_m == 4'd0) && !ctr_down);

    // Pin-level invariants
    int viol = 0;
    always @(negedge clk) begin
        if (!ctr_up && !ctr_down) viol <= viol + 1;
        if (!ctr_load_n && ctr_clr) viol <= viol + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int         lat;
    int         c_ld;
    int         c_clr;
    int         c_lo;
    logic [3:0] ld_d;

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] d);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = -1; c_ld = 0; c_clr = 0; c_lo = 0; ld_d = 4'd0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!ctr_load_n) begin c_ld++; ld_d = ctr_data; end
            if (ctr_clr) c_clr++;
            if (!ctr_up || !ctr_down) c_lo++;
            if (done) begin lat = k; break; end
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        int         exp_q;
        int         exp_wrap;
        int         exp_qerr;
        int         exp_lat;
        int         exp_ph;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int ph;
        int seen_done;
        logic ready_bad;

        vecs[0]  = '{2'b01, 4'd9,  9,  0, 0, 4,  2};
        vecs[1]  = '{2'b01, 4'd14, 14, 0, 0, 4,  2};
        vecs[2]  = '{2'b10, 4'd3,  1,  1, 0, 14, 6};
        vecs[3]  = '{2'b01, 4'd1,  1,  0, 0, 4,  2};
        vecs[4]  = '{2'b11, 4'd0,  1,  1, 0, 66, 32};
        vecs[5]  = '{2'b00, 4'd0,  0,  0, 0, 4,  2};
        vecs[6]  = '{2'b11, 4'd1,  15, 1, 0, 6,  2};
        vecs[7]  = '{2'b10, 4'd1,  0,  1, 0, 6,  2};
        vecs[8]  = '{2'b01, 4'd5,  5,  0, 0, 4,  2};
        vecs[9]  = '{2'b10, 4'd2,  7,  0, 0, 10, 4};
        vecs[10] = '{2'b11, 4'd3,  4,  0, 0, 14, 6};

        clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst ctr_clr",    int'(ctr_clr),    1);
        chk("rst ctr_load_n", int'(ctr_load_n), 1);
        chk("rst ctr_up",     int'(ctr_up),     1);
        chk("rst ctr_down",   int'(ctr_down),   1);
        chk("rst busy",       int'(busy),       0);
        chk("rst done",       int'(done),       0);
        chk("rst wrap",       int'(wrap),       0);
        chk("rst q_err",      int'(q_err),      0);
        chk("rst ctr_data",   int'(ctr_data),   0);
        chk("rst cmd_ready",  int'(cmd_ready),  1);
        chk("rst ctr_q",      int'(ctr_q),      0);
        clr = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].op, vecs[i].data);
            ph = (vecs[i].op == 2'b00) ? c_clr : (vecs[i].op == 2'b01) ? c_ld : c_lo;
            chk($sformatf("v%0d latency", i), lat,          vecs[i].exp_lat);
            chk($sformatf("v%0d ctr_q", i),   int'(ctr_q),  vecs[i].exp_q);
            chk($sformatf("v%0d wrap", i),    int'(wrap),   vecs[i].exp_wrap);
            chk($sformatf("v%0d q_err", i),   int'(q_err),  vecs[i].exp_qerr);
            chk($sformatf("v%0d phase", i),   ph,           vecs[i].exp_ph);
            if (vecs[i].op == 2'b01) chk($sformatf("v%0d ctr_data", i), int'(ld_d), int'(vecs[i].data));
        end

        // Dropped pulse: counter ends at 6, shadow at 7
        run_cmd(2'b01, 4'd5);
        drop_arm = 1'b1;
        run_cmd(2'b10, 4'd2);
        drop_arm = 1'b0;
        chk("drop latency", lat,         10);
        chk("drop ctr_q",   int'(ctr_q), 6);
        chk("drop q_err",   int'(q_err), 1);
        run_cmd(2'b00, 4'd7);
        chk("clr after drop q_err", int'(q_err), 0);
        chk("clr after drop ctr_q", int'(ctr_q), 0);

        // cmd_valid held with changing op/data while busy
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd7;
        @(posedge clk);
        lat = -1; c_lo = 0; c_clr = 0; ready_bad = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            #1 cmd_op = 2'(k); cmd_data = 4'(k + 3);
            @(negedge clk);
            if (cmd_ready) ready_bad = 1'b1;
            if (!ctr_up || !ctr_down) c_lo++;
            if (ctr_clr) c_clr++;
            if (done) begin lat = k; break; end
        end
        chk("hold latency",     lat,             4);
        chk("hold ready low",   int'(ready_bad), 0);
        @(negedge clk);
        chk("hold ready after", int'(cmd_ready), 1);
        cmd_valid = 1'b0;
        chk("hold ctr_q",       int'(ctr_q),     7);
        chk("hold no count",    c_lo + c_clr,    0);

        // clr in the middle of the 2nd pulse of a 4-pulse up from 3
        run_cmd(2'b01, 4'd3);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'd4;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("abort pre ctr_q", int'(ctr_q), 4);
        clr = 1'b1;
        #1;
        chk("abort ctr_clr", int'(ctr_clr), 1);
        chk("abort busy",    int'(busy),    0);
        chk("abort ctr_up",  int'(ctr_up),  1);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort no done", seen_done,   0);
        chk("abort ctr_q",   int'(ctr_q), 0);
        run_cmd(2'b10, 4'd1);
        chk("post-abort up ctr_q", int'(ctr_q), 1);
        chk("post-abort q_err",    int'(q_err), 0);
        run_cmd(2'b01, 4'd5);
        chk("post-abort load latency", lat,         4);
        chk("post-abort load ctr_q",   int'(ctr_q), 5);

        chk("pin invariants", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
